// File: rtl/stump_mem_pkg.sv
// Shared types and constants for the stump memory block: FSM states,
// latched request kinds, MMIO addresses and the value returned on a fault.
package stump_mem_pkg;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    typedef enum logic [1:0] {ReqRead, ReqWrite, ReqBad} req_e;

    localparam logic [15:0] MmioLedsAddr = 16'hFF00;
    localparam logic [15:0] MmioSwAddr   = 16'hFF01;
    localparam logic [15:0] FaultData    = 16'h0000;

endpackage

// File: rtl/stump_mem_array.sv
// Single-port 2**ADDR_BITS x 16 RAM: synchronous write, combinational read
// on the same address.
module stump_mem_array #(
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    localparam int unsigned Depth = 1 << ADDR_BITS;

    logic [15:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/stump_memory.sv
// Memory controller for the Stump processor: IDLE/WAIT/RESP handshake over a
// local RAM. Optional leds/switches MMIO is compiled in with STUMP_MEM_MMIO_EN.
module stump_memory
    import stump_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] data_wr,
    input  logic        mem_ren,
    input  logic        mem_wen,
    output logic [15:0] data_rd,
    output logic        ready,
    output logic        fault
`ifdef STUMP_MEM_MMIO_EN
    ,
    output logic [15:0] leds,
    input  logic [15:0] switches
`endif
);

    localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, wdata_q;
    req_e        kind_q, new_kind, cur_kind;
    logic [15:0] cur_addr;
    logic        accept, enter_resp;
    logic        in_ram, is_leds, is_sw, rsp_fault;
    logic [15:0] rsp_data, ram_rdata;
    logic        ram_we, leds_we;
    logic        ready_q, fault_q;
    logic [15:0] data_rd_q;

    always_comb begin
        if (mem_ren && mem_wen) begin
            new_kind = ReqBad;
        end else if (mem_wen) begin
            new_kind = ReqWrite;
        end else begin
            new_kind = ReqRead;
        end
    end

    // In IDLE the response is decoded from the live request so a zero-wait
    // access can be answered in the cycle right after acceptance.
    assign cur_addr = (state_q == StIdle) ? address : addr_q;
    assign cur_kind = (state_q == StIdle) ? new_kind : kind_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_ren || mem_wen) begin
                    accept = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end else begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign in_ram = (cur_addr >> ADDR_BITS) == 16'd0;

`ifdef STUMP_MEM_MMIO_EN
    logic [15:0] leds_q, sw_meta_q, sw_sync_q;

    assign is_leds = (cur_addr == MmioLedsAddr);
    assign is_sw   = (cur_addr == MmioSwAddr);
    assign leds    = leds_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q    <= 16'h0000;
            sw_meta_q <= 16'h0000;
            sw_sync_q <= 16'h0000;
        end else begin
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
            if (leds_we) begin
                leds_q <= wdata_q;
            end
        end
    end
`else
    assign is_leds = 1'b0;
    assign is_sw   = 1'b0;
`endif

    assign rsp_fault = (cur_kind == ReqBad) || !(in_ram || is_leds || is_sw) ||
                       ((cur_kind == ReqWrite) && is_sw);

    always_comb begin
        rsp_data = FaultData;
        if (!rsp_fault) begin
`ifdef STUMP_MEM_MMIO_EN
            if (is_leds) begin
                rsp_data = leds_q;
            end else if (is_sw) begin
                rsp_data = sw_sync_q;
            end else begin
                rsp_data = ram_rdata;
            end
`else
            rsp_data = ram_rdata;
`endif
        end
    end

    // Commits happen only on the edge that leaves RESP, so a reset during
    // WAIT or RESP drops the write.
    assign ram_we  = (state_q == StResp) && (kind_q == ReqWrite) && in_ram && !rst;
    assign leds_we = (state_q == StResp) && (kind_q == ReqWrite) && is_leds;

    stump_mem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .addr (cur_addr[ADDR_BITS-1:0]),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            data_rd_q <= 16'h0000;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            kind_q    <= ReqRead;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= enter_resp;
            fault_q <= enter_resp && rsp_fault;
            if (accept) begin
                addr_q  <= address;
                wdata_q <= data_wr;
                kind_q  <= new_kind;
            end
            // Write responses leave the last read data in place.
            if (enter_resp && (rsp_fault || (cur_kind == ReqRead))) begin
                data_rd_q <= rsp_data;
            end
        end
    end

    assign ready   = ready_q;
    assign fault   = fault_q;
    assign data_rd = data_rd_q;

endmodule
